// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encoding and default window width for the
//               switch debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int CNT_WIDTH_DEFAULT = 19;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,
        ST_WAIT1 = 2'b01,
        ST_ONE   = 2'b10,
        ST_WAIT0 = 2'b11
    } db_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : debounce_fsm
// Description : Switch debouncer; level changes only after the input has been
//               stable for 2^CNT_WIDTH cycles, with a rising-edge tick.
//               Macro DEBOUNCE_SYNC_EN inserts a two-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 w_sw_s;
    db_state_t            r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_level;
    logic                 r_tick;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (w_sw_s)
    );
`else
    assign w_sw_s = sw;
`endif

    // A reversal during a wait always beats the counter==0 check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ZERO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_ZERO: begin
                    r_level <= 1'b0;
                    if (w_sw_s) begin
                        r_state <= ST_WAIT1;
                        r_cnt   <= '1;
                    end
                end
                ST_WAIT1: begin
                    if (!w_sw_s) begin
                        r_state <= ST_ZERO;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_ONE;
                        r_level <= 1'b1;
                        r_tick  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end
                end
                ST_ONE: begin
                    r_level <= 1'b1;
                    if (!w_sw_s) begin
                        r_state <= ST_WAIT0;
                        r_cnt   <= '1;
                    end
                end
                ST_WAIT0: begin
                    if (w_sw_s) begin
                        r_state <= ST_ONE;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_ZERO;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_ZERO;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign db_level = r_level;
    assign db_tick  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_debounce_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_fsm
// Description : Randomized self-checking bench for debounce_fsm against a
//               run-length reference model (CNT_WIDTH = 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_fsm;

    localparam int CW  = 3;
    localparam int WIN = 1 << CW;

    logic clk = 1'b0;
    logic rst;
    logic sw;
    logic db_level;
    logic db_tick;

    always #5 clk = ~clk;

    debounce_fsm #(.CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the level flips once the sampled input has disagreed with it
    // for WIN+1 consecutive edges; any agreeing sample restarts the run.
    bit m_level;
    bit m_tick;
    bit m_s1;
    bit m_s2;
    int m_run;
    int tick_seen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s);
        bit x;
        rst = r;
        sw  = s;
        @(posedge clk);
        if (r) begin
            m_level = 0; m_tick = 0; m_run = 0; m_s1 = 0; m_s2 = 0;
        end else begin
`ifdef DEBOUNCE_SYNC_EN
            x    = m_s2;
            m_s2 = m_s1;
            m_s1 = s;
`else
            x = s;
`endif
            m_tick = 0;
            if (x != m_level) m_run++;
            else              m_run = 0;
            if (m_run == WIN + 1) begin
                m_level = x;
                m_tick  = x;
                m_run   = 0;
            end
        end
        @(negedge clk);
        check_eq("db_level", {31'd0, db_level}, {31'd0, m_level});
        check_eq("db_tick",  {31'd0, db_tick},  {31'd0, m_tick});
        if (db_tick === 1'b1) tick_seen++;
    endtask

    task automatic hold(input logic s, input int n);
        for (int i = 0; i < n; i++) step(1'b0, s);
    endtask

    initial begin
        rst = 1'b1;
        sw  = 1'b0;
        @(negedge clk);

        // Reset with the switch already high
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Clean press: exactly one tick
        tick_seen = 0;
        hold(1'b1, WIN + 6);
        check_eq("press_ticks", tick_seen, 1);
        check_eq("press_level", {31'd0, db_level}, 1);

        // Short low glitch while high, then a full release
        hold(1'b0, 3);
        hold(1'b1, 4);
        check_eq("glitch_level", {31'd0, db_level}, 1);
        tick_seen = 0;
        hold(1'b0, WIN + 6);
        check_eq("release_ticks", tick_seen, 0);
        check_eq("release_level", {31'd0, db_level}, 0);

        // Bounce rejection: 5 high then low
        tick_seen = 0;
        hold(1'b1, 5);
        hold(1'b0, 6);
        check_eq("bounce_ticks", tick_seen, 0);

        // Reset mid-count, then a full window from scratch
        hold(1'b1, 4);
        step(1'b1, 1'b1);
        hold(1'b1, WIN + 4);

        // Toggling every cycle never debounces
        hold(1'b0, WIN + 4);
        tick_seen = 0;
        for (int i = 0; i < 40; i++) step(1'b0, i[0]);
        check_eq("toggle_ticks", tick_seen, 0);

        // Randomized hold lengths around the window, with occasional resets
        for (int h = 0; h < 80; h++) begin
            logic v;
            int   n;
            v = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, WIN + 5));
            for (int i = 0; i < n; i++)
                step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
